// File: rtl/hall_speed_meter_if.sv
// Hall sensor input and speed-sample output bundle between the Hall front end,
// the speed meter and the downstream PID stage.
interface hall_speed_meter_if;
    logic [2:0] h;
    logic [7:0] speed;
    logic       dir;
    logic       fault;
    logic       sample_stb;

    modport master (input h, output speed, dir, fault, sample_stb);
    modport slave  (output h, input speed, dir, fault, sample_stb);
endinterface

// File: rtl/hall_speed_meter.sv
// Hall-sensor speed/direction meter: synchronizes and debounces H, classifies
// each accepted state change and publishes one speed sample per window.
module hall_speed_meter #(
    parameter int unsigned WINDOW     = 50000,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    hall_speed_meter_if.master bus
);
    localparam int unsigned   WW       = $clog2(WINDOW);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 32'd1);
    localparam logic [WW-1:0] WIN_ONE  = WW'(32'd1);
    localparam logic [7:0]    DEB_LIM  = 8'(DEB_CYCLES - 32'd1);

    function automatic logic [2:0] fwd_next(input logic [2:0] s);
        case (s)
            3'b001:  fwd_next = 3'b011;
            3'b011:  fwd_next = 3'b010;
            3'b010:  fwd_next = 3'b110;
            3'b110:  fwd_next = 3'b100;
            3'b100:  fwd_next = 3'b101;
            3'b101:  fwd_next = 3'b001;
            default: fwd_next = 3'b000;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] s);
        is_illegal = (s == 3'b000) || (s == 3'b111);
    endfunction

    logic [2:0]    sync1_q, sync1_d;
    logic [2:0]    h_sync_q, h_sync_d;
    logic [7:0]    stab_cnt_q, stab_cnt_d;
    logic [2:0]    h_stable_q, h_stable_d;
    logic          prev_valid_q, prev_valid_d;
    logic [7:0]    edge_cnt_q, edge_cnt_d;
    logic          fault_acc_q, fault_acc_d;
    logic          dir_acc_q, dir_acc_d;
    logic [WW-1:0] win_cnt_q, win_cnt_d;
    logic [7:0]    speed_q, speed_d;
    logic          dir_q, dir_d;
    logic          fault_q, fault_d;
    logic          stb_q, stb_d;

    logic       accept_s;
    logic       step_fwd_s;
    logic       step_rev_s;
    logic       fault_now_s;
    logic [7:0] edge_sum_s;
    logic       fault_sum_s;
    logic       dir_now_s;

    // Synchronizer and debounce: the stability counter holds (edges held - 1).
    always_comb begin
        sync1_d  = bus.h;
        h_sync_d = sync1_q;
        if (sync1_q != h_sync_q) begin
            stab_cnt_d = 8'd0;
        end else if (stab_cnt_q != 8'hFF) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
        accept_s = (h_sync_q != h_stable_q) && (stab_cnt_q >= DEB_LIM);
    end

    // Step classification of an accepted state against the previous stable state.
    always_comb begin
        h_stable_d   = h_stable_q;
        prev_valid_d = prev_valid_q;
        step_fwd_s   = 1'b0;
        step_rev_s   = 1'b0;
        fault_now_s  = 1'b0;
        if (accept_s) begin
            h_stable_d = h_sync_q;
            if (is_illegal(h_sync_q)) begin
                fault_now_s = 1'b1;
            end else if (!prev_valid_q || is_illegal(h_stable_q)) begin
                prev_valid_d = 1'b1;
            end else if (fwd_next(h_stable_q) == h_sync_q) begin
                step_fwd_s = 1'b1;
            end else if (fwd_next(h_sync_q) == h_stable_q) begin
                step_rev_s = 1'b1;
            end else begin
                fault_now_s = 1'b1;
            end
        end else begin
            h_stable_d = h_stable_q;
        end
    end

    // Window accumulation; same-cycle steps and faults land in the closing sample.
    always_comb begin
        if ((step_fwd_s || step_rev_s) && (edge_cnt_q != 8'hFF)) begin
            edge_sum_s = edge_cnt_q + 8'd1;
        end else begin
            edge_sum_s = edge_cnt_q;
        end
        if (step_fwd_s) begin
            dir_now_s = 1'b1;
        end else if (step_rev_s) begin
            dir_now_s = 1'b0;
        end else begin
            dir_now_s = dir_acc_q;
        end
        fault_sum_s = fault_acc_q | fault_now_s;
        dir_acc_d   = dir_now_s;

        if (win_cnt_q == WIN_LAST) begin
            win_cnt_d   = '0;
            edge_cnt_d  = 8'd0;
            fault_acc_d = 1'b0;
            speed_d     = edge_sum_s;
            dir_d       = dir_now_s;
            fault_d     = fault_sum_s;
            stb_d       = 1'b1;
        end else begin
            win_cnt_d   = win_cnt_q + WIN_ONE;
            edge_cnt_d  = edge_sum_s;
            fault_acc_d = fault_sum_s;
            speed_d     = speed_q;
            dir_d       = dir_q;
            fault_d     = fault_q;
            stb_d       = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 3'b000;
            h_sync_q     <= 3'b000;
            stab_cnt_q   <= 8'd0;
            h_stable_q   <= 3'b000;
            prev_valid_q <= 1'b0;
            edge_cnt_q   <= 8'd0;
            fault_acc_q  <= 1'b0;
            dir_acc_q    <= 1'b0;
            win_cnt_q    <= '0;
            speed_q      <= 8'd0;
            dir_q        <= 1'b0;
            fault_q      <= 1'b0;
            stb_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            h_sync_q     <= h_sync_d;
            stab_cnt_q   <= stab_cnt_d;
            h_stable_q   <= h_stable_d;
            prev_valid_q <= prev_valid_d;
            edge_cnt_q   <= edge_cnt_d;
            fault_acc_q  <= fault_acc_d;
            dir_acc_q    <= dir_acc_d;
            win_cnt_q    <= win_cnt_d;
            speed_q      <= speed_d;
            dir_q        <= dir_d;
            fault_q      <= fault_d;
            stb_q        <= stb_d;
        end
    end

    assign bus.speed      = speed_q;
    assign bus.dir        = dir_q;
    assign bus.fault      = fault_q;
    assign bus.sample_stb = stb_q;
endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: directed table, hand sequences and random Hall
// activity checked against a window-level reference model.
module tb_hall_speed_meter;
    localparam int WA  = 1000;
    localparam int WB  = 4000;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    hall_speed_meter_if ifa ();
    hall_speed_meter_if ifb ();

    hall_speed_meter #(.WINDOW(WA), .DEB_CYCLES(DEB)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    hall_speed_meter #(.WINDOW(WB), .DEB_CYCLES(DEB)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb.master));

    typedef struct {
        int         edge_at;
        int         t_drv;
        logic [2:0] v;
    } acc_t;

    typedef struct {
        logic [23:0] seq;
        int          n;
        int          gap;
        logic [7:0]  speed;
        logic        dir;
        logic        fault;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         cyc;
    acc_t       q[$];
    logic [2:0] fseq[6];
    logic [2:0] m_stable;
    bit         m_valid;
    int         m_cnt;
    bit         m_fault;
    bit         m_dir;
    int         exp_speed;
    bit         exp_dir;
    bit         exp_fault;
    bit         exp_stb;
    vec_t       tbl[6];

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", nm, act, expv, cyc, $time);
        end
    endtask

    function automatic int pos(input logic [2:0] v);
        for (int i = 0; i < 6; i++) if (fseq[i] == v) return i;
        return -1;
    endfunction

    task automatic model_accept(input logic [2:0] v);
        int po, pn;
        if (v == m_stable) return;
        po = pos(m_stable);
        pn = pos(v);
        if (pn < 0) m_fault = 1'b1;
        else if (!m_valid || po < 0) m_valid = 1'b1;
        else if (pn == (po + 1) % 6) begin m_cnt++; m_dir = 1'b1; end
        else if (po == (pn + 1) % 6) begin m_cnt++; m_dir = 1'b0; end
        else m_fault = 1'b1;
        m_stable = v;
    endtask

    // A value is accepted DEB+2 edges after it is driven, but only if held >= DEB cycles.
    task automatic drive(input logic [2:0] v);
        acc_t e;
        if (q.size() > 0 && q[q.size() - 1].t_drv > cyc - DEB) q.delete(q.size() - 1);
        ifa.h = v;
        e.edge_at = cyc + 2 + DEB;
        e.t_drv = cyc;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic model_reset();
        acc_t e;
        q.delete();
        m_stable = 3'b000; m_valid = 1'b0; m_cnt = 0; m_fault = 1'b0; m_dir = 1'b0;
        exp_speed = 0; exp_dir = 1'b0; exp_fault = 1'b0;
        cyc = 0;
        e.edge_at = 2 + DEB;
        e.t_drv = 0;
        e.v = ifa.h;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        while (q.size() > 0 && q[0].edge_at == cyc) begin
            model_accept(q[0].v);
            q.delete(0);
        end
        if (cyc % WA == 0) begin
            exp_speed = (m_cnt > 255) ? 255 : m_cnt;
            exp_fault = m_fault;
            exp_dir = m_dir;
            m_cnt = 0;
            m_fault = 1'b0;
            exp_stb = 1'b1;
        end else begin
            exp_stb = 1'b0;
        end
        @(negedge clk);
        chk("stb", ifa.sample_stb, exp_stb);
        chk("speed", ifa.speed, exp_speed);
        chk("dir", ifa.dir, exp_dir);
        chk("fault", ifa.fault, exp_fault);
    endtask

    task automatic to_strobe();
        do tick(); while (cyc % WA != 0);
    endtask

    task automatic chk_out(input string nm, input int sp, input int dr, input int ft, input int sb);
        chk({nm, "_speed"}, ifa.speed, sp);
        chk({nm, "_dir"}, ifa.dir, dr);
        chk({nm, "_fault"}, ifa.fault, ft);
        chk({nm, "_stb"}, ifa.sample_stb, sb);
    endtask

    initial begin
        logic [2:0] nv, cur, g;
        int r, hb;
        bit rdir;
        fseq[0] = 3'b001; fseq[1] = 3'b011; fseq[2] = 3'b010;
        fseq[3] = 3'b110; fseq[4] = 3'b100; fseq[5] = 3'b101;
        tbl[0] = '{{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b000}, 7, 50, 8'd6, 1'b1, 1'b0};
        tbl[1] = '{24'h000000, 0, 50, 8'd0, 1'b1, 1'b0};
        tbl[2] = '{{3'b001, 3'b101, 3'b100, 3'b011, 12'h000}, 4, 40, 8'd2, 1'b0, 1'b1};
        tbl[3] = '{{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b000}, 7, 45, 8'd6, 1'b0, 1'b0};
        tbl[4] = '{{3'b111, 3'b010, 3'b110, 15'h0000}, 3, 50, 8'd1, 1'b1, 1'b1};
        tbl[5] = '{24'h000000, 0, 50, 8'd0, 1'b1, 1'b0};

        // Reset behaviour with H held at 001.
        rst = 1'b1; rst_b = 1'b1; ifa.h = 3'b001; ifb.h = 3'b001; cyc = 0;
        repeat (3) @(negedge clk);
        chk_out("rst0", 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        to_strobe();
        chk("first_stb_cyc", cyc, 1000);
        chk_out("first_stb", 0, 0, 0, 1);

        // Directed windows from the table.
        for (int k = 0; k < 6; k++) begin
            repeat (10) tick();
            for (int i = 0; i < tbl[k].n; i++) begin
                nv = tbl[k].seq[(7 - i) * 3 +: 3];
                if (nv != ifa.h) drive(nv);
                repeat (tbl[k].gap) tick();
            end
            to_strobe();
            chk_out($sformatf("vec%0d", k), tbl[k].speed, tbl[k].dir, tbl[k].fault, 1);
        end

        // Glitch rejection: skip back to 001, then a 3-cycle and a 5-cycle pulse.
        repeat (10) tick();
        drive(3'b001);
        to_strobe();
        repeat (10) tick();
        drive(3'b000); repeat (3) tick(); drive(3'b001);
        to_strobe();
        chk_out("glitch3", 0, 1, 0, 1);
        repeat (10) tick();
        drive(3'b000); repeat (5) tick(); drive(3'b001);
        to_strobe();
        chk_out("glitch5", 0, 1, 1, 1);

        // Reset mid-window after a counted window.
        repeat (10) tick();
        for (int i = 1; i <= 5; i++) begin drive(fseq[i]); repeat (50) tick(); end
        to_strobe();
        chk_out("pre_rst", 5, 1, 0, 1);
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin drive(fseq[i]); repeat (50) tick(); end
        while (cyc % WA != 600) tick();
        rst = 1'b1;
        #1;
        chk_out("mid_rst", 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) tick();
        for (int i = 3; i < 6; i++) begin drive(fseq[i]); repeat (50) tick(); end
        to_strobe();
        chk("post_rst_cyc", cyc, 1000);
        chk_out("post_rst", 3, 1, 0, 1);

        // Random Hall activity against the model.
        rdir = 1'b1;
        repeat (400) begin
            cur = ifa.h;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 19) == 0) rdir = ~rdir;
            if (r < 60) begin
                if (pos(cur) < 0) nv = fseq[$urandom_range(0, 5)];
                else nv = rdir ? fseq[(pos(cur) + 1) % 6] : fseq[(pos(cur) + 5) % 6];
                if (nv != cur) drive(nv);
            end else if (r < 80) begin
                nv = 3'($urandom_range(0, 7));
                if (nv != cur) drive(nv);
            end else begin
                g = 3'($urandom_range(0, 7));
                if (g != cur) begin
                    drive(g);
                    repeat ($urandom_range(1, DEB - 1)) tick();
                    drive(cur);
                end
            end
            repeat ($urandom_range(DEB + 1, 30)) tick();
        end
        to_strobe();

        // Saturation on the long-window instance.
        hb = 0;
        @(negedge clk);
        rst_b = 1'b0;
        for (int c = 1; c <= 8000; c++) begin
            @(negedge clk);
            if (c == 1) chk("sat_reset_speed", ifb.speed, 0);
            if (c == 3999) chk("sat_stb_early", ifb.sample_stb, 0);
            if (c == 4000) begin
                chk("sat_stb", ifb.sample_stb, 1);
                chk("sat_speed", ifb.speed, 255);
                chk("sat_dir", ifb.dir, 1);
                chk("sat_fault", ifb.fault, 0);
            end
            if (c == 8000) begin
                chk("after_sat_stb", ifb.sample_stb, 1);
                chk("after_sat_speed", ifb.speed, 50);
            end
            if ((c >= 20 && c < 3020 && c % 10 == 0) || (c >= 4100 && c < 4600 && c % 10 == 0)) begin
                hb = (hb + 1) % 6;
                ifb.h = fseq[hb];
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
